reservoir_dispatcher: RTL
=========================

# reservoir_dispatcher

Demand-side dispatcher that drives the release request (`req`) into the reservoir controller and consumes its `now`, `out` and `electric` results. Each cycle it converts the grid load into a registered release request whose policy depends on the reservoir level and tracks accumulated unmet energy. It sits between the grid-load source and the reservoir top and closes the request/response loop the reservoir exposes.

## Interface
- `DRY_LEVEL`, 8: below this level the block is in DROUGHT.
- `LOW_LEVEL`, 32: below this level the block is in CONSERVE.
- `HYST`, 8: the block leaves CONSERVE only when `now >= LOW_LEVEL + HYST`.
- `HIGH_LEVEL`, 200: above this level the block is in SPILL.
- `SPILL_REQ`, 64: minimum request while in SPILL.
- `PAYBACK`, 8: extra request added in NORMAL while `shortfall > 0`.
- `ALARM_CYCLES`, 8: number of consecutive DROUGHT cycles before `alarm` asserts.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `load` input 8: grid energy demand for this cycle.
- `load_valid` input 1: `load` is meaningful this cycle.
- `now` input 8: current reservoir level.
- `out` input 8: water released by the reservoir. Monitored only; it has no effect on the outputs.
- `electric` input 8: energy generated by the reservoir this cycle.
- `req` output 8: registered release request sent to the reservoir.
- `mode` output 2: current policy state.
- `shortfall` output 16: saturating accumulated unmet energy.
- `alarm` output 1: DROUGHT has persisted for too long.

## Operation
- **States:** NORMAL=0, CONSERVE=1, DROUGHT=2, SPILL=3.
- **Next-state evaluation:** evaluated every cycle from `now` and the current `mode`, in priority order:
  - `now < DRY_LEVEL` → DROUGHT.
  - else `now > HIGH_LEVEL` → SPILL.
  - else `now < LOW_LEVEL` → CONSERVE.
  - else, if currently CONSERVE and `now < LOW_LEVEL + HYST` → stay in CONSERVE.
  - otherwise → NORMAL.
- **Request, computed from the next state when `load_valid=1`:**
  - NORMAL: `load + PAYBACK` if `shortfall > 0`, else `load`.
  - CONSERVE: `load >> 1`.
  - DROUGHT: 0.
  - SPILL: `max(load, SPILL_REQ)`.
  - All sums saturate at 255. There is no wrap-around.
- **Request when `load_valid=0`:** `req` holds its value and `shortfall` holds. `mode` still updates. Entering or staying in DROUGHT forces `req=0` regardless of `load_valid`.
- **Shortfall update (only when `load_valid=1`):**
  - If `electric < load`: `shortfall += load - electric`, saturating at 0xFFFF.
  - Otherwise: `shortfall -= min(shortfall, electric - load)`, never going below 0.
- **Alarm:** a consecutive-DROUGHT counter increments each cycle in DROUGHT and saturates at `ALARM_CYCLES`. It clears on any edge whose next state is not DROUGHT. `alarm = (count == ALARM_CYCLES)`.

## Timing
- **Reset values:** `req=0`, `mode=NORMAL`, `shortfall=0`, `alarm=0`, alarm counter = 0.
- **Reset assertion:** applies immediately and asynchronously, including mid-operation. No partial state survives.
- **Latency:** one cycle. Inputs sampled at edge N appear on `req`, `mode` and `shortfall` after edge N.
- **Shortfall timing:** `shortfall` at edge N uses the `shortfall` value before edge N to decide the PAYBACK term.
- **Alarm timing:** `alarm` rises on the `ALARM_CYCLES`-th consecutive DROUGHT edge. It falls on the same edge that `mode` leaves DROUGHT.
- **Simultaneous events:** a level crossing and a `load_valid` change in the same cycle are handled together. State priority alone decides the result.

## Configuration
- **`RESERVOIR_DISPATCH_ALARM_EN` defined:** the alarm counter and `alarm` logic are compiled in, behaving as described above.
- **`RESERVOIR_DISPATCH_ALARM_EN` undefined:** the counter is absent and `alarm` is tied to 0. All other behaviour is identical.

## Structure
- **Shared package `reservoir_pkg`:** holds the mode encodings (NORMAL, CONSERVE, DROUGHT, SPILL) and the default threshold constants. The reservoir top and the benches use the same package.
- **Sub-module `shortfall_acc`:** the 16-bit saturating signed-difference accumulator. Inputs: `clk`, `rst`, `en`, `load`, `electric`. Output: `shortfall`.
- **Top level:** holds the policy FSM, the request logic and the alarm counter.

## Test plan
- **Reset:** assert `rst=0` while `req=24` and `mode=SPILL` → all outputs go to their reset values immediately, without waiting for a clock edge.
- **NORMAL steady state:** `now=100`, `load=24`, `electric=24`, `load_valid=1` → after one edge `req=24`, `mode=0`, `shortfall=0`.
- **Hysteresis:** `now=20`, `load=32` → `mode=1`, `req=16`. Then `now=36` → `mode` stays 1. Then `now=40` → `mode=0`, `req=32`.
- **Drought and alarm:** `now=5`, `load=16` for 8 edges → `req=0`, `mode=2`, `alarm=1` on the 8th edge. Then `now=50` → `mode=0`, `alarm=0` on the same edge.
- **Shortfall and payback:**
  - `now=100`, `load=16`, `electric=10` for 3 edges → `shortfall=18`; `req` is 16 on the first edge, then 24 once `shortfall > 0`.
  - Then `electric=30` → `shortfall=4`.
  - Then `load_valid=0` → `req` and `shortfall` hold.
- **Spill and saturation:** `now=210`, `load=16` → `mode=3`, `req=64`. Then `load=100` → `req=100`. Then `now=100`, `shortfall>0`, `load=252` → `req=255`.

Source files
------------

// File: rtl/reservoir_pkg.sv
// ============================================================================
//  Package     : reservoir_pkg
//  Description : Mode encodings, default thresholds and a saturating-add
//                helper shared by the reservoir dispatcher and its benches.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package reservoir_pkg;

  // Policy states; the numeric values are visible on the mode output.
  typedef enum logic [1:0] {
    NORMAL   = 2'd0,
    CONSERVE = 2'd1,
    DROUGHT  = 2'd2,
    SPILL    = 2'd3
  } mode_e;

  // Default thresholds.
  localparam logic [7:0] DRY_LEVEL_DEF    = 8'd8;
  localparam logic [7:0] LOW_LEVEL_DEF    = 8'd32;
  localparam logic [7:0] HYST_DEF         = 8'd8;
  localparam logic [7:0] HIGH_LEVEL_DEF   = 8'd200;
  localparam logic [7:0] SPILL_REQ_DEF    = 8'd64;
  localparam logic [7:0] PAYBACK_DEF      = 8'd8;
  localparam int         ALARM_CYCLES_DEF = 8;

  // 8-bit add that clamps at 255 instead of wrapping.
  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

endpackage : reservoir_pkg

`default_nettype wire

// File: rtl/reservoir_dispatcher_shortfall_acc.sv
// ============================================================================
//  Module      : shortfall_acc
//  Description : 16-bit accumulator of unmet energy. Adds (load - electric)
//                when generation falls short, subtracts the surplus otherwise;
//                clamps at 0xFFFF and at 0.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shortfall_acc (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [7:0]  load,
  input  logic [7:0]  electric,
  output logic [15:0] shortfall
);

  logic [15:0] shortfall_q;
  logic [15:0] shortfall_d;
  logic [16:0] w_sum;
  logic [7:0]  w_deficit;
  logic [7:0]  w_surplus;

  // Next accumulator value; only one of deficit/surplus is meaningful per cycle.
  always_comb begin
    w_deficit   = load - electric;
    w_surplus   = electric - load;
    w_sum       = {1'b0, shortfall_q} + {9'd0, w_deficit};
    shortfall_d = shortfall_q;
    if (en) begin
      if (electric < load) begin
        shortfall_d = w_sum[16] ? 16'hFFFF : w_sum[15:0];
      end else if (shortfall_q < {8'd0, w_surplus}) begin
        shortfall_d = 16'd0;
      end else begin
        shortfall_d = shortfall_q - {8'd0, w_surplus};
      end
    end
  end

  // Accumulator register with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shortfall_q <= 16'd0;
    end else begin
      shortfall_q <= shortfall_d;
    end
  end

  assign shortfall = shortfall_q;

endmodule : shortfall_acc

`default_nettype wire

// File: rtl/reservoir_dispatcher.sv
// ============================================================================
//  Module      : reservoir_dispatcher
//  Description : Converts grid load into a registered release request whose
//                policy (NORMAL/CONSERVE/DROUGHT/SPILL) follows the reservoir
//                level, tracks unmet energy, and flags prolonged drought.
//  Config      : RESERVOIR_DISPATCH_ALARM_EN - compiles in the drought alarm
//                counter; when undefined alarm is tied to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reservoir_dispatcher
  import reservoir_pkg::*;
#(
  parameter logic [7:0] DRY_LEVEL    = DRY_LEVEL_DEF,
  parameter logic [7:0] LOW_LEVEL    = LOW_LEVEL_DEF,
  parameter logic [7:0] HYST         = HYST_DEF,
  parameter logic [7:0] HIGH_LEVEL   = HIGH_LEVEL_DEF,
  parameter logic [7:0] SPILL_REQ    = SPILL_REQ_DEF,
  parameter logic [7:0] PAYBACK      = PAYBACK_DEF,
  parameter int         ALARM_CYCLES = ALARM_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  load,
  input  logic        load_valid,
  input  logic [7:0]  now,
  input  logic [7:0]  out,
  input  logic [7:0]  electric,
  output logic [7:0]  req,
  output logic [1:0]  mode,
  output logic [15:0] shortfall,
  output logic        alarm
);

  // Level at which CONSERVE is released; 9 bits so LOW_LEVEL + HYST cannot wrap.
  localparam logic [8:0] LEAVE_LEVEL = {1'b0, LOW_LEVEL} + {1'b0, HYST};

  mode_e      mode_q;
  mode_e      mode_d;
  logic [7:0] req_q;
  logic [7:0] req_d;
  logic [7:0] w_payback;

  // The released-water feedback is observed only; it does not steer policy.
  logic unused_out;
  assign unused_out = ^out;

  // Policy next state, in priority order: drought, spill, conserve, hysteresis.
  always_comb begin
    mode_d = NORMAL;
    if (now < DRY_LEVEL) begin
      mode_d = DROUGHT;
    end else if (now > HIGH_LEVEL) begin
      mode_d = SPILL;
    end else if (now < LOW_LEVEL) begin
      mode_d = CONSERVE;
    end else if ((mode_q == CONSERVE) && ({1'b0, now} < LEAVE_LEVEL)) begin
      mode_d = CONSERVE;
    end
  end

  // Request for the state being entered; payback uses the pre-edge shortfall.
  always_comb begin
    w_payback = (shortfall != 16'd0) ? PAYBACK : 8'd0;
    req_d     = req_q;
    if (mode_d == DROUGHT) begin
      req_d = 8'd0;
    end else if (load_valid) begin
      case (mode_d)
        NORMAL:   req_d = sat_add8(load, w_payback);
        CONSERVE: req_d = load >> 1;
        SPILL:    req_d = (load < SPILL_REQ) ? SPILL_REQ : load;
        default:  req_d = 8'd0;
      endcase
    end
  end

  // Policy state and request registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q <= NORMAL;
      req_q  <= 8'd0;
    end else begin
      mode_q <= mode_d;
      req_q  <= req_d;
    end
  end

  assign mode = mode_q;
  assign req  = req_q;

  shortfall_acc u_shortfall_acc (
    .clk       (clk),
    .rst       (rst),
    .en        (load_valid),
    .load      (load),
    .electric  (electric),
    .shortfall (shortfall)
  );

`ifdef RESERVOIR_DISPATCH_ALARM_EN
  localparam int CNT_W = $clog2(ALARM_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ALARM_CYCLES);

  logic [CNT_W-1:0] cnt_q;

  // Consecutive-drought counter; saturates at the alarm threshold, clears on exit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (mode_d != DROUGHT) begin
      cnt_q <= '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign alarm = (cnt_q == CNT_MAX);
`else
  logic [7:0] unused_alarm_cfg;
  assign unused_alarm_cfg = 8'(ALARM_CYCLES);
  assign alarm = 1'b0;
`endif

endmodule : reservoir_dispatcher

`default_nettype wire
